// File: rtl/logic_op_if.sv
// ---------------------------------------------------------------------------
// logic_op_if
//
// Operand/result bundle for logic_op_pipe.
//
//   enable     pipeline advance strobe (0 = every register holds)
//   in_valid   operands and op are valid this cycle
//   op         3-bit operation select
//   a, b       WIDTH-bit operands
//   accum_clr  restart the running accumulation
//   z          registered result
//   out_valid  z holds a newly delivered result this cycle
//   z_zero     registered flag: z == 0
//   z_ones     registered flag: z == all ones
//
// master: the operand producer. slave: the pipeline itself.
// ---------------------------------------------------------------------------
interface logic_op_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             accum_clr;
    logic [WIDTH-1:0] z;
    logic             out_valid;
    logic             z_zero;
    logic             z_ones;

    modport master (
        output enable, in_valid, op, a, b, accum_clr,
        input  z, out_valid, z_zero, z_ones
    );

    modport slave (
        input  enable, in_valid, op, a, b, accum_clr,
        output z, out_valid, z_zero, z_ones
    );
endinterface

// File: rtl/logic_op_pipe.sv
// ---------------------------------------------------------------------------
// logic_op_pipe
//
// Selectable bitwise logic operation on two WIDTH-bit operands, carried
// through a LATENCY-deep valid-tagged pipeline that stalls on enable, with a
// running AND/OR accumulator living in stage 1.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    logic_op_if.slave: enable, in_valid, op, a, b, accum_clr in;
//          z, out_valid, z_zero, z_ones out
//
// Timing: a transaction accepted at enabled edge N is delivered on z with
// out_valid=1 after enabled edge N+LATENCY-1 (LATENCY=1 delivers at the
// accepting edge). Bubbles keep z and its flags at the last delivered value.
// ---------------------------------------------------------------------------
module logic_op_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    logic_op_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_NAND    = 3'b011,
        OP_NOR     = 3'b100,
        OP_XNOR    = 3'b101,
        OP_ACC_AND = 3'b110,
        OP_ACC_OR  = 3'b111
    } op_e;

    // -----------------------------------------------------------------------
    // Stage 1: operation and accumulator
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] acc;
    logic             acc_empty;
    logic [WIDTH-1:0] r;
    logic             accept;
    logic             acc_op;
    logic             start_fresh;

    assign accept = bus.enable & bus.in_valid;
    assign acc_op = bus.op[2] & bus.op[1];

    // A clear in the same cycle as an ACC op takes effect first, so the op
    // starts from its own operands rather than the stale accumulator.
    assign start_fresh = acc_empty | bus.accum_clr;

    always_comb begin
        // NOTE: default assigned first so every path drives r; no latch is inferred.
        r = '0;
        case (op_e'(bus.op))
            OP_AND:     r = bus.a & bus.b;
            OP_OR:      r = bus.a | bus.b;
            OP_XOR:     r = bus.a ^ bus.b;
            OP_NAND:    r = ~(bus.a & bus.b);
            OP_NOR:     r = ~(bus.a | bus.b);
            OP_XNOR:    r = ~(bus.a ^ bus.b);
            OP_ACC_AND: r = start_fresh ? (bus.a & bus.b) : (acc & bus.a & bus.b);
            OP_ACC_OR:  r = start_fresh ? (bus.a | bus.b) : (acc | bus.a | bus.b);
            default:    r = '0;
        endcase
    end

    // Accumulator is written at the accepting edge, so a back-to-back ACC op
    // sees it on the very next cycle without any forwarding path.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            acc       <= '0;
            acc_empty <= 1'b1;
        end else if (bus.enable) begin
            if (accept && acc_op) begin
                acc       <= r;
                acc_empty <= 1'b0;
            end else if (bus.accum_clr) begin
                acc_empty <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Intermediate stages: whatever arrives at the output register this edge
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] arr_data;
    logic             arr_valid;

    generate
        if (LATENCY == 1) begin : g_direct
            assign arr_data  = r;
            assign arr_valid = accept;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_data [LATENCY-1];
            logic [LATENCY-2:0] pipe_valid;

            // Only the valid tags need reset; data behind a cleared tag is
            // never observed.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe_valid <= '0;
                end else if (bus.enable) begin
                    pipe_valid[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // NOTE: datapath storage has no reset; only the valid tags qualify it.
            always_ff @(posedge clk) begin
                if (bus.enable) begin
                    pipe_data[0] <= r;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_data[i] <= pipe_data[i-1];
                    end
                end
            end

            assign arr_data  = pipe_data[LATENCY-2];
            assign arr_valid = pipe_valid[LATENCY-2];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output stage: z and flags only move when a valid result arrives
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] z_q;
    logic             out_valid_q;
    logic             z_zero_q;
    logic             z_ones_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q         <= '0;
            out_valid_q <= 1'b0;
            z_zero_q    <= 1'b1;
            z_ones_q    <= 1'b0;
        end else if (bus.enable) begin
            out_valid_q <= arr_valid;
            if (arr_valid) begin
                z_q      <= arr_data;
                z_zero_q <= (arr_data == '0);
                z_ones_q <= (&arr_data);
            end
        end
    end

    assign bus.z         = z_q;
    assign bus.out_valid = out_valid_q;
    assign bus.z_zero    = z_zero_q;
    assign bus.z_ones    = z_ones_q;

endmodule
